rv_fetch_unit: RTL and testbench
================================

# rv_fetch_unit

Parametrised instruction-fetch front end for the RV32I core. Generalises the single-cycle program-counter/instruction-memory pair into a decoupled fetcher: it issues word requests to a variable-latency instruction memory over a request/grant/response handshake and buffers up to `DEPTH` instructions in an in-order prefetch queue. It also handles branch/jump redirects by flushing the queue and discarding stale in-flight responses. It sits between the instruction memory port and the decode/control stage.

## Interface
- `XLEN`, 32: address and PC width.
- `DEPTH`, 4: prefetch queue entries and maximum requests in flight; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `redirect_valid` in 1: branch/jump taken; flush and refetch.
- `redirect_pc` in XLEN: new fetch address; bits [1:0] are ignored and treated as 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: word-aligned request address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid. Responses return in order, at least 1 cycle after `imem_gnt`.
- `imem_rdata` in 32: response instruction word.
- `instr_valid` out 1: instruction available to decode.
- `instr_ready` in 1: decode accepts the instruction this cycle.
- `instr` out 32: instruction word; `NOP_INSTR` when `instr_valid`=0.
- `instr_pc` out XLEN: PC of `instr`.

## Operation
- Registers:
  - `fetch_pc`: next request address.
  - `resp_pc`: PC of the next expected response.
  - `outstanding`: granted requests not yet returned, 0..DEPTH.
  - `discard_cnt`.
  - Queue of {pc, instr}, `count` 0..DEPTH.
- FSM states:
  - RUN: normal fetching.
  - FLUSH: draining stale responses.
- Issue rule:
  - `imem_req`=1 only when: in RUN, and `count + outstanding < DEPTH`, and `redirect_valid`=0.
  - `imem_addr`=`fetch_pc`.
  - Once asserted, `imem_req` and `imem_addr` are held stable until `imem_gnt`. The only exceptions are redirect and reset.
- On grant:
  - `fetch_pc` += 4 (wraps modulo 2^XLEN).
  - `outstanding`++.
- On response in RUN:
  - Push {`resp_pc`, `imem_rdata`}.
  - `resp_pc` += 4.
  - `outstanding`--.
- Pop:
  - Happens when `instr_valid && instr_ready`.
  - Simultaneous push and pop leaves `count` unchanged.
- The credit rule guarantees a response never arrives while the queue is full. An overflow is a protocol error: data is dropped, and an assertion fires in simulation.
- Redirect (either state):
  - Queue cleared; `count`=0.
  - `fetch_pc` and `resp_pc` set to {`redirect_pc`[XLEN-1:2], 2'b00}.
  - `discard_cnt` = `outstanding` + `imem_gnt` − `imem_rvalid`. This value includes the current cycle's grant and excludes the current cycle's response, which is dropped.
  - A pop in the same cycle is ignored.
  - Next state: FLUSH if `discard_cnt`>0, else RUN.
- FLUSH:
  - No requests.
  - Each `imem_rvalid` decrements `discard_cnt` and `outstanding`; the data is dropped.
  - Return to RUN when the last stale response arrives.
  - A redirect during FLUSH reloads the PCs; discard counting continues.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `instr_valid`=0, `instr`=NOP_INSTR, `instr_pc`=RESET_PC.
  - FSM=RUN; all counters 0.
- First `imem_req` is in the first cycle after `rst_n` is sampled high.
- `rst_n` low mid-operation: all state returns to reset values at the next edge. Later responses to pre-reset grants are the memory's responsibility to squash.
- Latency:
  - A response at edge N is visible on `instr`/`instr_valid` from cycle N+1.
  - Peak throughput is one instruction per cycle when the memory grants every cycle.
- `instr_valid` does not depend combinationally on `instr_ready`.
- The redirect cycle produces `instr_valid`=0 in the following cycle.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the queue is empty and in RUN with no redirect, `imem_rdata` is forwarded combinationally to `instr`, with `instr_valid`=1 and `instr_pc`=`resp_pc` in the same cycle.
  - If popped that cycle, the word is not enqueued.
  - Latency 0.
- `FETCH_BYPASS_EN` undefined: all outputs come registered from the queue; latency 1.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {RUN, FLUSH}.
  - `NOP_INSTR` = 32'h0000_0013 (addi x0,x0,0).
  - `INSTR_W` = 32.
- Sub-module `sync_fifo`:
  - Parametrised width/depth.
  - Synchronous flush input.
  - `count` output.
  - Instantiated once for {pc, instr}.
- PC tracking uses `resp_pc` arithmetic; there is no address queue.

## Test plan
- Reset release, memory grants every cycle with 1-cycle response → fetch addresses 0,4,8,…; `instr_pc` 0,4,8 on consecutive cycles; `instr_valid` from cycle 2 (1 with bypass).
- `instr_ready`=0 with DEPTH=4 → exactly 4 grants, then `imem_req`=0. Then `instr_ready`=1 → requests resume; no word lost or duplicated.
- `imem_gnt` held low 3 cycles → `imem_req`/`imem_addr` stable throughout.
- Redirect to 0x100 with 2 outstanding plus a grant in the same cycle → 3 responses dropped; first delivered `instr_pc`=0x100.
- Redirect to 0x203 in FLUSH → reads target 0x200, and stale responses are still counted out.
- Fetch from 0xFFFF_FFFC → next address 0x0000_0000; reset asserted mid-burst → reset outputs at the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: fetch_state_t (RUN/FLUSH), NOP_INSTR, INSTR_W.
package fetch_pkg;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a synchronous flush and an occupancy count.
// Latency: a push is visible at head_dat_o from the next cycle.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
// Ports: clk, rst_n (sync, active-low), flush_i, push_i/push_dat_i, pop_i,
//        head_dat_o (oldest entry), count_o (0..DEPTH), full_o.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_dat_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o     = (count_q == CW'(DEPTH));
   assign count_o    = count_q;
   assign head_dat_o = mem_q[rd_ptr_q];
   assign do_pop     = pop_i && (count_q != '0);
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign do_push    = push_i && (!full_o || do_pop);

   // Storage carries no reset: entries are only observed through count_q.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/rv_fetch_unit.sv
// Decoupled RV32I fetcher: credit-limited word requests into an in-order prefetch queue.
// Latency: response to instr 1 cycle (0 cycles with FETCH_BYPASS_EN defined).
// Backpressure: requests stop once queued + in-flight reaches DEPTH; redirect flushes.
// Ports: clk, rst_n (sync, active-low); redirect_valid/redirect_pc; imem_req/imem_addr/
//        imem_gnt request channel; imem_rvalid/imem_rdata in-order responses;
//        instr_valid/instr_ready/instr/instr_pc towards decode.
// Optional: `FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module rv_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [XLEN-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [XLEN-1:0]    instr_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int QW = XLEN + INSTR_W;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic            active_q;

   logic [QW-1:0]   q_head;
   logic [CW-1:0]   q_count;
   logic            q_full;
   logic            q_push;
   logic            q_pop;
   logic            q_empty;

   logic            credit_ok;
   logic            run_ok;
   logic            gnt_acc;
   logic            rsp;
   logic            byp;
   logic [XLEN-1:0] redir_tgt;
   logic [1:0]      unused_redir_lsb;

   assign unused_redir_lsb = redirect_pc[1:0];
   assign redir_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
   assign q_empty          = (q_count == '0);

   // Every queued or in-flight word owns one queue slot, so a granted response
   // always finds room.
   assign credit_ok = ({1'b0, q_count} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
   // active_q holds requests off until the first cycle after reset is released.
   assign run_ok    = active_q && (state_q == RUN) && credit_ok;
   assign imem_req  = run_ok && !redirect_valid;
   assign imem_addr = fetch_pc_q;

   // A grant landing in a redirect cycle is still a real memory transaction
   // (it answered the request presented before the redirect dropped it), so it
   // is counted and later discarded.
   assign gnt_acc = imem_gnt && run_ok;
   assign rsp     = imem_rvalid && (outst_q != '0);

`ifdef FETCH_BYPASS_EN
   assign byp = q_empty && active_q && (state_q == RUN) && !redirect_valid && rsp;
`else
   assign byp = 1'b0;
`endif

   assign instr_valid = !q_empty || byp;
   assign instr       = !q_empty ? q_head[INSTR_W-1:0] : (byp ? imem_rdata : NOP_INSTR);
   assign instr_pc    = !q_empty ? q_head[QW-1:INSTR_W] : resp_pc_q;

   assign q_pop  = !q_empty && instr_ready && !redirect_valid;
   // A bypassed word consumed by decode this cycle never enters the queue.
   assign q_push = rsp && (state_q == RUN) && !redirect_valid && !(byp && instr_ready);

   sync_fifo #(
      .WIDTH (QW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (redirect_valid),
      .push_i     (q_push),
      .push_dat_i ({resp_pc_q, imem_rdata}),
      .pop_i      (q_pop),
      .head_dat_o (q_head),
      .count_o    (q_count),
      .full_o     (q_full)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      discard_d  = discard_q;
      outst_d    = outst_q + CW'(gnt_acc) - CW'(rsp);
      if (redirect_valid) begin
         // Everything still in flight after this edge is stale, including a
         // grant in this cycle; a response in this cycle is simply dropped.
         fetch_pc_d = redir_tgt;
         resp_pc_d  = redir_tgt;
         discard_d  = outst_d;
         state_d    = (outst_d != '0) ? FLUSH : RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               if (gnt_acc) fetch_pc_d = fetch_pc_q + XLEN'(4);
               if (rsp)     resp_pc_d  = resp_pc_q + XLEN'(4);
            end
            FLUSH: begin
               if (rsp) begin
                  discard_d = discard_q - CW'(1);
                  if (discard_q == CW'(1)) state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         active_q   <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   // A response arriving with the queue full means the memory broke the credit contract.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(q_push && q_full && !q_pop))
            else $error("rv_fetch_unit: prefetch queue overflow, response dropped");
      end
   end
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Self-checking bench for rv_fetch_unit: directed table/sequences plus random traffic
// against an in-order memory model and a delivered-stream reference (PC sequence + data).
module tb_rv_fetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   rv_fetch_unit #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // memory model: granted addresses in order, with cycles since grant
   logic [31:0] mq[$];
   int          mage[$];

   logic        s_req, s_valid;
   logic [31:0] s_addr, s_instr, s_pc;
   logic        prev_req, prev_gnt;
   logic [31:0] prev_addr;
   logic [31:0] exp_pc;
   logic [31:0] first_pc;
   logic        want_first;
   int          n_deliv;
   int          n_gnt;

   typedef struct {
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t tbl[6];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive at negedge, sample combinational outputs, then
   // advance the reference and memory model as of the following posedge.
   task automatic step(input logic redir, input logic [31:0] tgt, input logic gnt_en,
                       input logic force_gnt, input logic rv_en, input logic rdy);
      @(negedge clk);
      redirect_valid = redir;
      redirect_pc    = tgt;
      #1;
      s_req  = imem_req;
      s_addr = imem_addr;
      imem_gnt = force_gnt | (s_req & gnt_en);
      if (mq.size() > 0 && mage[0] >= 1 && rv_en) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mq[0]);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      instr_ready = rdy;
      #1;
      s_valid = instr_valid;
      s_instr = instr;
      s_pc    = instr_pc;

      if (redir) chk("req_off_on_redirect", 32'(s_req), 32'd0);
      if (prev_req && !prev_gnt && !redir) begin
         chk("req_hold", 32'(s_req), 32'd1);
         chk("addr_hold", s_addr, prev_addr);
      end
      if (!s_valid) chk("nop_when_idle", s_instr, NOP_INSTR);
      if (s_req) chk("credit_limit", 32'(mq.size() < DEPTH), 32'd1);

      if (redir) begin
         exp_pc     = {tgt[31:2], 2'b00};
         want_first = 1'b1;
      end else if (s_valid && rdy) begin
         chk("deliv_pc", s_pc, exp_pc);
         chk("deliv_instr", s_instr, mem_word(exp_pc));
         if (want_first) begin
            first_pc   = s_pc;
            want_first = 1'b0;
         end
         exp_pc = exp_pc + 32'd4;
         n_deliv++;
      end

      prev_req  = s_req;
      prev_gnt  = imem_gnt;
      prev_addr = s_addr;
      if (imem_rvalid) begin
         void'(mq.pop_front());
         void'(mage.pop_front());
      end
      if (imem_gnt) begin
         mq.push_back(s_addr);
         mage.push_back(0);
         n_gnt++;
      end
      foreach (mage[i]) mage[i] = mage[i] + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      instr_ready    = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, NOP_INSTR);
      chk("rst_pc", instr_pc, RESET_PC);
      @(negedge clk);
      rst_n = 1'b1;
      mq.delete();
      mage.delete();
      exp_pc     = RESET_PC;
      prev_req   = 1'b0;
      prev_gnt   = 1'b0;
      want_first = 1'b0;
      first_pc   = 32'hFFFF_FFFF;
   endtask

   initial begin
      int g0, d0;
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      n_deliv = 0; n_gnt = 0;

      for (int k = 0; k < 6; k++) begin
         tbl[k].exp_req   = 1'b1;
         tbl[k].exp_addr  = 32'(4 * k);
         tbl[k].exp_valid = (k >= 1 + LAT);
         tbl[k].exp_pc    = 32'(4 * (k - 1 - LAT));
      end

      // Reset release, grant every cycle, 1-cycle response.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
         chk($sformatf("tbl%0d_req", k), 32'(s_req), 32'(tbl[k].exp_req));
         chk($sformatf("tbl%0d_addr", k), s_addr, tbl[k].exp_addr);
         chk($sformatf("tbl%0d_valid", k), 32'(s_valid), 32'(tbl[k].exp_valid));
         if (tbl[k].exp_valid) chk($sformatf("tbl%0d_pc", k), s_pc, tbl[k].exp_pc);
      end

      // Decode stalled: exactly DEPTH grants, then requests stop; then resume.
      do_reset();
      g0 = n_gnt;
      for (int k = 0; k < 12; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("stall_grants", 32'(n_gnt - g0), 32'(DEPTH));
      chk("stall_req_off", 32'(s_req), 32'd0);
      d0 = n_deliv;
      for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("resume_grants", 32'(n_gnt - g0 > DEPTH), 32'd1);
      chk("resume_deliv", 32'(n_deliv - d0 >= 10), 32'd1);

      // Grant withheld 3 cycles: request and address stay put.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
         chk("nogrant_req", 32'(s_req), 32'd1);
         chk("nogrant_addr", s_addr, RESET_PC);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("after_grant_addr", s_addr, RESET_PC + 32'd4);

      // Redirect with 2 outstanding plus a grant in the redirect cycle: 3 stale.
      do_reset();
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("stale_in_flight", 32'(mq.size()), 32'd3);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
         chk("flush_no_req", 32'(s_req), 32'd0);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("post_flush_addr", s_addr, 32'h100);
      for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("redir_first_pc", first_pc, 32'h100);

      // Redirect during FLUSH to an unaligned target.
      do_reset();
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h203, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("flush2_no_req", 32'(s_req), 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("flush2_req", 32'(s_req), 32'd1);
      chk("flush2_addr", s_addr, 32'h200);
      for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("flush2_first_pc", first_pc, 32'h200);

      // Address wrap, then reset mid-burst.
      do_reset();
      step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("wrap_addr1", s_addr, 32'h0000_0000);
      for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("wrap_first_pc", first_pc, 32'hFFFF_FFFC);
      do_reset();
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("post_rst_req", 32'(s_req), 32'd1);
      chk("post_rst_addr", s_addr, RESET_PC);

      // Random traffic against the reference stream.
      do_reset();
      d0 = n_deliv;
      for (int k = 0; k < 1500; k++) begin
         logic rd;
         rd = ($urandom_range(0, 39) == 0);
         step(rd, $urandom, ($urandom_range(0, 3) != 0), 1'b0,
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      end
      chk("rand_progress", 32'(n_deliv - d0 > 200), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
